// File: rtl/audio_i2s_tx.sv
// Multi-channel serial audio transmitter (I2S, left-justified or TDM).
// Frames are buffered in a FIFO and serialised MSB-first with generated BCLK/LRCLK.
module audio_i2s_tx #(
    parameter int SAMPLE_W   = 16,
    parameter int SLOT_W     = 32,
    parameter int CHANNELS   = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int SCLK_DIV   = 8,
    parameter int MODE       = 0
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic                             En,
    input  logic                             Mute,
    input  logic [CHANNELS*SAMPLE_W-1:0]     In_Data,
    input  logic                             In_Valid,
    output logic                             In_Ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  Fifo_Level,
    output logic                             Underrun,
    input  logic                             Underrun_Clr,
    output logic                             Frame_Pulse,
    output logic                             I2S_BCLK,
    output logic                             I2S_LRCLK,
    output logic                             I2S_DOUT
);
    localparam int FRAME_W = CHANNELS * SAMPLE_W;
    localparam int N       = CHANNELS * SLOT_W;
    localparam int BIT_W   = (N > 1) ? $clog2(N) : 1;
    localparam int DIV_W   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    logic [FRAME_W-1:0] mem [FIFO_DEPTH];
    logic [FRAME_W-1:0] rd_data;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic               fifo_empty, push, pop;

    state_t             state;
    logic [DIV_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_idx, next_idx;
    logic [N-1:0]       fifo_frame, load_frame, shift_reg;
    logic               div_wrap, fall, at_wrap, stop, load;
    logic               lj_bit, lj_prev, next_lr;

    assign fifo_empty = (Fifo_Level == '0);
    assign In_Ready   = (Fifo_Level != LVL_W'(FIFO_DEPTH));
    assign push       = In_Valid && In_Ready;
    assign rd_data    = mem[rd_ptr];

    // NOTE: sample storage has no reset; the pointers and level alone say what is valid.
    always_ff @(posedge Clk) begin
        if (push) mem[wr_ptr] <= In_Data;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            Fifo_Level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   Fifo_Level <= Fifo_Level + LVL_W'(1);
                2'b01:   Fifo_Level <= Fifo_Level - LVL_W'(1);
                default: ;
            endcase
        end
    end

    // Transmit-order frame: slot 0 occupies the top SLOT_W bits, sample left-aligned in its slot.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
        assign fifo_frame[N-1-k*SLOT_W -: SLOT_W] =
            SLOT_W'(rd_data[k*SAMPLE_W +: SAMPLE_W]) << (SLOT_W - SAMPLE_W);
    end

    assign div_wrap   = (div_cnt == DIV_W'(SCLK_DIV - 1));
    assign fall       = (state != IDLE) && div_wrap && I2S_BCLK;
    assign at_wrap    = (bit_idx == BIT_W'(N - 1));
    assign next_idx   = at_wrap ? '0 : bit_idx + BIT_W'(1);
    assign stop       = fall && at_wrap && (state == DRAIN) && !En;
    assign load       = fall && at_wrap && !stop;
    assign pop        = load && !fifo_empty;
    assign load_frame = (Mute || fifo_empty) ? '0 : fifo_frame;
    assign lj_bit     = load ? load_frame[N-1] : shift_reg[N-1];
    assign next_lr    = (MODE == 2) ? (next_idx == '0)
                                    : (((32'(next_idx) / SLOT_W) % 2) != 0);

    always_ff @(posedge Clk) begin
        if (Reset)                    Underrun <= 1'b0;
        else if (load && fifo_empty)  Underrun <= 1'b1;
        else if (Underrun_Clr)        Underrun <= 1'b0;
    end

    // NOTE: all state here is non-blocking so every branch sees the pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            div_cnt     <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            lj_prev     <= 1'b0;
            Frame_Pulse <= 1'b0;
            I2S_BCLK    <= 1'b0;
            I2S_LRCLK   <= 1'b0;
            I2S_DOUT    <= 1'b0;
        end else begin
            Frame_Pulse <= load;
            case (state)
                IDLE: begin
                    div_cnt   <= '0;
                    I2S_BCLK  <= 1'b0;
                    I2S_LRCLK <= 1'b0;
                    I2S_DOUT  <= 1'b0;
                    lj_prev   <= 1'b0;
                    if (En) begin
                        state   <= RUN;
                        bit_idx <= BIT_W'(N - 1);
                    end
                end
                default: begin
                    if (state == RUN && !En)       state <= DRAIN;
                    else if (state == DRAIN && En) state <= RUN;
                    div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
                    if (div_wrap) I2S_BCLK <= !I2S_BCLK;
                    if (stop) begin
                        state     <= IDLE;
                        bit_idx   <= '0;
                        lj_prev   <= 1'b0;
                        I2S_LRCLK <= 1'b0;
                        I2S_DOUT  <= 1'b0;
                    end else if (fall) begin
                        bit_idx   <= next_idx;
                        I2S_LRCLK <= next_lr;
                        I2S_DOUT  <= (MODE == 1) ? lj_bit : lj_prev;
                        lj_prev   <= lj_bit;
                        shift_reg <= load ? (load_frame << 1) : (shift_reg << 1);
                    end
                end
            endcase
        end
    end
endmodule
